thread_fetch: RTL and testbench

THREAD_FETCH -- requirements
Module: thread_fetch

---
 rtl/arya_pkg.sv | 15 +
 rtl/rr_thread_arbiter.sv | 40 ++++
 rtl/thread_fetch.sv | 95 +++++++++
 tb/tb_thread_fetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arya_pkg.sv
// Shared constants for the barrel-threaded fetch front end.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Provides the default instruction address width, thread id width,
// derived thread count and the reset PC used by thread_fetch and
// rr_thread_arbiter.
package arya_pkg;

  localparam int INST_ADDR_WIDTH_DEF = 9;
  localparam int THREAD_BITS_DEF     = 2;
  localparam int NUM_THREADS         = 2 ** THREAD_BITS_DEF;
  localparam int RESET_PC_DEF        = 0;

endpackage

// File: rtl/rr_thread_arbiter.sv
// Round-robin thread picker: first active thread after tp, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to consume the pick.
//
// Ports:
//   tp          - thread issued last
//   mask        - one bit per thread, 1 = eligible
//   next_thread - selected thread (0 when none eligible)
//   any_valid   - at least one thread is eligible
module rr_thread_arbiter
  import arya_pkg::*;
#(
  parameter int THREAD_BITS = THREAD_BITS_DEF
) (
  input  logic [THREAD_BITS-1:0]      tp,
  input  logic [(2**THREAD_BITS)-1:0] mask,
  output logic [THREAD_BITS-1:0]      next_thread,
  output logic                        any_valid
);

  localparam int N_THR = 2 ** THREAD_BITS;

  logic [THREAD_BITS-1:0] cand;

  // Scan tp+1 .. tp+N_THR; the last candidate wraps back to tp itself,
  // so a single active thread is re-issued every cycle.
  always_comb begin
    next_thread = '0;
    any_valid   = 1'b0;
    cand        = '0;
    for (int i = 1; i <= N_THR; i++) begin
      cand = tp + THREAD_BITS'(i);
      if (!any_valid && mask[cand]) begin
        next_thread = cand;
        any_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_fetch.sv
// Barrel-threaded fetch: one PC per thread, round-robin issue, branch redirect.
// Latency: one cycle from select to registered pc_out/thread_id_out/fetch_valid_out.
// Backpressure: en=0 stalls and holds all outputs and state; redirects still land.
//
// Ports:
//   clk, reset       - single clock, synchronous active-high reset
//   en               - advance enable (low = stall)
//   branch_taken_in  - redirect PC[branch_thread_in] to branch_pc_in+branch_offset_in
//   branch_thread_in, branch_pc_in, branch_offset_in (signed)
//   pc_out, thread_id_out, fetch_valid_out - registered fetch request
//   thread_active_in - per-thread eligibility, present only with THREAD_MASK_EN
//
// Optional feature macro: THREAD_MASK_EN (adds thread_active_in; without it
// every thread is always eligible).
module thread_fetch
  import arya_pkg::*;
#(
  parameter int INST_ADDR_WIDTH = INST_ADDR_WIDTH_DEF,
  parameter int THREAD_BITS     = THREAD_BITS_DEF,
  parameter int RESET_PC        = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       branch_taken_in,
  input  logic [THREAD_BITS-1:0]     branch_thread_in,
  input  logic [INST_ADDR_WIDTH-1:0] branch_pc_in,
  input  logic [INST_ADDR_WIDTH-1:0] branch_offset_in,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic [THREAD_BITS-1:0]     thread_id_out,
  output logic                       fetch_valid_out
`ifdef THREAD_MASK_EN
  ,
  input  logic [(2**THREAD_BITS)-1:0] thread_active_in
`endif
);

  localparam int N_THR = 2 ** THREAD_BITS;

  logic [INST_ADDR_WIDTH-1:0] pc_q [N_THR];
  logic [THREAD_BITS-1:0]     tp_q;
  logic [N_THR-1:0]           active;
  logic [THREAD_BITS-1:0]     sel;
  logic                       sel_vld;
  logic [INST_ADDR_WIDTH-1:0] branch_target;

`ifdef THREAD_MASK_EN
  assign active = thread_active_in;
`else
  assign active = '1;
`endif

  // Offset is two's complement at full PC width, so a plain modular add
  // gives the sign-extended, truncated target.
  assign branch_target = branch_pc_in + branch_offset_in;

  rr_thread_arbiter #(
    .THREAD_BITS (THREAD_BITS)
  ) u_arb (
    .tp          (tp_q),
    .mask        (active),
    .next_thread (sel),
    .any_valid   (sel_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_THR; i++) begin
        pc_q[i] <= INST_ADDR_WIDTH'(RESET_PC);
      end
      tp_q            <= THREAD_BITS'(N_THR - 1);
      pc_out          <= '0;
      thread_id_out   <= '0;
      fetch_valid_out <= 1'b0;
    end else begin
      if (en) begin
        if (sel_vld) begin
          pc_out          <= pc_q[sel];
          thread_id_out   <= sel;
          fetch_valid_out <= 1'b1;
          tp_q            <= sel;
          pc_q[sel]       <= pc_q[sel] + 1'b1;
        end else begin
          fetch_valid_out <= 1'b0;
        end
      end
      // Placed after the increment so the redirect wins when both hit
      // the same thread in one cycle.
      if (branch_taken_in) begin
        pc_q[branch_thread_in] <= branch_target;
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch.sv
module tb_thread_fetch;

  localparam int W    = 9;
  localparam int TB   = 2;
  localparam int NT   = 4;
  localparam int MODP = 512;
  localparam int RPC  = 0;

  logic          clk;
  logic          reset;
  logic          en;
  logic          branch_taken_in;
  logic [TB-1:0] branch_thread_in;
  logic [W-1:0]  branch_pc_in;
  logic [W-1:0]  branch_offset_in;
  logic [W-1:0]  pc_out;
  logic [TB-1:0] thread_id_out;
  logic          fetch_valid_out;
  logic [NT-1:0] mask_drv;

  thread_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .en               (en),
    .branch_taken_in  (branch_taken_in),
    .branch_thread_in (branch_thread_in),
    .branch_pc_in     (branch_pc_in),
    .branch_offset_in (branch_offset_in),
    .pc_out           (pc_out),
    .thread_id_out    (thread_id_out),
    .fetch_valid_out  (fetch_valid_out)
`ifdef THREAD_MASK_EN
    ,
    .thread_active_in (mask_drv)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit v;
    int th;
    int pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: architectural state only.
  int m_pc[NT];
  int m_tp;
  int m_mask;
  bit e_v;
  int e_th;
  int e_pc;

  function automatic int pick();
    for (int k = 1; k <= NT; k++) begin
      int c;
      c = (m_tp + k) % NT;
      if (m_mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic step(input bit rst, input bit e, input bit bt, input int bth,
                      input int bpc, input int boff, input int msk);
    int t;
    int soff;
    exp_t x;
    @(negedge clk);
    reset            = rst;
    en               = e;
    branch_taken_in  = bt;
    branch_thread_in = TB'(bth);
    branch_pc_in     = W'(bpc);
    branch_offset_in = W'(boff);
    mask_drv         = NT'(msk);
`ifdef THREAD_MASK_EN
    m_mask = msk;
`else
    m_mask = 'hF;
`endif
    if (rst) begin
      for (int i = 0; i < NT; i++) m_pc[i] = RPC;
      m_tp = NT - 1;
      e_v  = 0;
      e_th = 0;
      e_pc = 0;
    end else begin
      if (e) begin
        t = pick();
        if (t >= 0) begin
          e_v     = 1;
          e_th    = t;
          e_pc    = m_pc[t];
          m_tp    = t;
          m_pc[t] = (m_pc[t] + 1) % MODP;
        end else begin
          e_v = 0;
        end
      end
      if (bt) begin
        soff      = (boff >= MODP / 2) ? boff - MODP : boff;
        m_pc[bth] = (((bpc + soff) % MODP) + MODP) % MODP;
      end
    end
    x.v  = e_v;
    x.th = e_th;
    x.pc = e_pc;
    sb.push_back(x);
  endtask

  task automatic run(input int n, input int msk);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, msk);
  endtask

  task automatic run_until_next(input int t);
    for (int i = 0; i < 2 * NT; i++) begin
      if (pick() == t) break;
      step(0, 1, 0, 0, 0, 0, 'hF);
    end
  endtask

  // Monitor: one expected entry per clock edge after stimulus starts.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_cmp++;
        if (fetch_valid_out !== x.v || int'(thread_id_out) != x.th ||
            int'(pc_out) != x.pc || $isunknown({fetch_valid_out, thread_id_out, pc_out})) begin
          n_err++;
          $display("FAIL fetch_out @%0t: got v=%0b th=%0d pc=%0d, want v=%0b th=%0d pc=%0d",
                   $time, fetch_valid_out, thread_id_out, pc_out, x.v, x.th, x.pc);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; en = 1'b0; branch_taken_in = 1'b0;
    branch_thread_in = '0; branch_pc_in = '0; branch_offset_in = '0;
    mask_drv = '1;
    m_mask = 'hF; m_tp = NT - 1; e_v = 0; e_th = 0; e_pc = 0;
    for (int i = 0; i < NT; i++) m_pc[i] = RPC;

    // Reset state, then the plain 8-cycle round robin.
    step(1, 1, 1, 1, 7, 7, 'hF);
    step(1, 0, 0, 0, 0, 0, 'hF);
    run(8, 'hF);

    // Stall mid-sequence, then resume.
    run(2, 'hF);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 'hF);
    run(4, 'hF);

    // Redirect thread 2 to 10-4 in the cycle thread 2 is issued.
    run_until_next(2);
    step(0, 1, 1, 2, 10, 'h1FC, 'hF);
    run(4, 'hF);

    // Thread 1 at 511 wraps to 0.
    step(0, 1, 1, 1, 511, 0, 'hF);
    run(8, 'hF);

`ifdef THREAD_MASK_EN
    run(4, 'hA);
    step(0, 1, 0, 0, 0, 0, 'h0);
    step(0, 1, 1, 3, 100, 5, 'h0);
    step(0, 1, 0, 0, 0, 0, 'h0);
    run(4, 'hF);
`endif

    // Reset mid-run with en and a redirect active.
    run(3, 'hF);
    step(1, 1, 1, 2, 55, 3, 'hF);
    run(6, 'hF);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int msk;
`ifdef THREAD_MASK_EN
      msk = ($urandom_range(0, 3) == 0) ? 'hF : int'($urandom_range(0, 15));
`else
      msk = 'hF;
`endif
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, NT - 1)),
           int'($urandom_range(0, MODP - 1)),
           ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MODP - 1)), msk);
    end

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
